// File: rtl/maxpool3x3s2_stream.sv
// Streaming 3x3 stride-2 max pool: horizontal max in r_hreg, vertical max in a one-row partial buffer.
// Optional ReLU seed on each window max when MAXPOOL_RELU_EN is defined.
module maxpool3x3s2_stream #(
  parameter int IN_W   = 111,
  parameter int IN_H   = 111,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);
  localparam int OUT_W = (IN_W - 3) / 2 + 1;
  localparam int CW    = $clog2(IN_W);
  localparam int RW    = $clog2(IN_H);
  localparam int JW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [DATA_W-1:0] r_hreg;
  logic [DATA_W-1:0] r_pbuf [OUT_W];
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;

  logic              w_acc, w_col_end, w_row_end, w_issue, w_emit;
  logic [JW-1:0]     w_j;
  logic [DATA_W-1:0] w_hmax, w_vmax, w_win;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_acc     = in_valid && in_ready;
  assign w_col_end = (r_col == CW'(IN_W - 1));
  assign w_row_end = (r_row == RW'(IN_H - 1));
  // Horizontal window closes on every even column past 0; vertical on every even row past 0.
  assign w_issue   = w_acc && !r_col[0] && (r_col != '0);
  assign w_emit    = w_issue && !r_row[0] && (r_row != '0);
  assign w_j       = JW'(r_col[CW-1:1] - 1'b1);
  assign w_hmax    = smax(r_hreg, in_data);
  assign w_vmax    = smax(r_pbuf[w_j], w_hmax);
`ifdef MAXPOOL_RELU_EN
  assign w_win     = smax(w_vmax, '0);
`else
  assign w_win     = w_vmax;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_hreg <= '0;
    end else if (soft_clr) begin
      r_col  <= '0;
      r_row  <= '0;
      r_hreg <= '0;
    end else if (w_acc) begin
      r_col  <= w_col_end ? '0 : r_col + 1'b1;
      if (w_col_end) r_row <= w_row_end ? '0 : r_row + 1'b1;
      // Even columns (incl. 0) start a new window with the current pixel.
      r_hreg <= r_col[0] ? w_hmax : in_data;
    end
  end

  // Buffer contents need no reset: row 0 always overwrites before any read.
  always_ff @(posedge clk) begin
    if (w_issue && !soft_clr)
      r_pbuf[w_j] <= r_row[0] ? w_vmax : w_hmax;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (soft_clr) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_win;
      r_out_last  <= w_row_end && w_col_end;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
endmodule

// File: tb/tb_maxpool3x3s2_stream.sv
// Directed bench for maxpool3x3s2_stream: ramp, reverse ramp, negative, spike channels,
// backpressure, async reset and soft clear mid-channel.
module tb_maxpool3x3s2_stream;
  localparam int W = 111, H = 111, OW = 55, NOUT = 3025, NB = W * H;

  logic        clk = 1'b0, rst_n = 1'b0, soft_clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid, out_last;
  logic [15:0] out_data;

  int checks = 0, errors = 0, oi = 0;
  int kinds[$];

  maxpool3x3s2_stream dut (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // kind 0 ramp, 1 reverse ramp, 2 all 0xFF00, 3 single spike at (2,2)
  function automatic logic [15:0] pix(input int kind, input int r, input int c);
    case (kind)
      0: return 16'(r * W + c);
      1: return 16'(12320 - (r * W + c));
      2: return 16'hFF00;
      default: return (r == 2 && c == 2) ? 16'h7FFF : 16'h0100;
    endcase
  endfunction

  function automatic logic [15:0] expv(input int n);
    int ch, loc, i, j;
    ch = n / NOUT; loc = n % NOUT; i = loc / OW; j = loc % OW;
    if (ch >= kinds.size()) return 16'hDEAD;
    case (kinds[ch])
      0: return 16'((2 * i + 2) * W + 2 * j + 2);
      1: return 16'(12320 - (2 * i * W + 2 * j));
`ifdef MAXPOOL_RELU_EN
      2: return 16'h0000;
`else
      2: return 16'hFF00;
`endif
      default: return (i <= 1 && j <= 1) ? 16'h7FFF : 16'h0100;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (out index %0d)", tag, obs, exp, oi);
    end
  endtask

  task automatic check_out();
    chk("out_data", 32'(out_data), 32'(expv(oi)));
    chk("out_last", 32'(out_last), 32'((oi % NOUT) == NOUT - 1));
  endtask

  // Entered and left at posedge+1; drives nbeats beats of one channel.
  task automatic stream(input int kind, input int nbeats, input bit bp);
    int b = 0, guard = 0;
    bit ti, to;
    kinds.push_back(kind);
    while (b < nbeats && guard < nbeats * 4 + 200) begin
      in_valid  = 1'b1;
      in_data   = pix(kind, b / W, b % W);
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (out_valid) check_out();
      ti = in_ready;
      to = out_valid && out_ready;
      @(posedge clk); #1;
      if (ti) b++;
      if (to) oi++;
      guard++;
    end
    in_valid = 1'b0;
    chk("beats_accepted", 32'(b), 32'(nbeats));
  endtask

  task automatic drain(input int want);
    int g = 0;
    bit to;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (oi < want && g < 200) begin
      #1;
      if (out_valid) check_out();
      to = out_valid;
      @(posedge clk); #1;
      if (to) oi++;
      g++;
    end
    chk("out_count", 32'(oi), 32'(want));
    chk("idle_after_drain", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp at full rate, then reverse ramp back-to-back under random backpressure.
    stream(0, NB, 1'b0);
    stream(1, NB, 1'b1);
    drain(2 * NOUT);

    // Async reset mid-channel right after an emitting beat (row 44, col 2).
    kinds.delete(); oi = 0;
    stream(2, 44 * W + 3, 1'b0);
    out_ready = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    kinds.delete(); oi = 0;
    stream(2, NB, 1'b1);
    drain(NOUT);

    // soft_clr at row 60 with a stalled output.
    kinds.delete(); oi = 0;
    stream(0, 60 * W + 3, 1'b0);
    out_ready = 1'b0;
    #1;
    chk("pre_clr_valid", 32'(out_valid), 32'd1);
    soft_clr = 1'b1;
    @(posedge clk); #1;
    soft_clr = 1'b0;
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_out_data", 32'(out_data), 32'd0);
    chk("clr_out_last", 32'(out_last), 32'd0);
    kinds.delete(); oi = 0;
    stream(3, NB, 1'b0);
    drain(NOUT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
